// File: rtl/mcu_subsys_bus_decoder_if.sv
// CPU memory port plus the fanned-out target ports of the bus decoder.
// slave  : decoder view (serves the CPU, drives the targets)
// master : environment view (CPU driving requests, targets answering)
interface mcu_subsys_bus_decoder_if #(
  parameter int NUM_TGT = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic                        cpu_mem_valid;
  logic                        cpu_mem_ready;
  logic [ADDR_W-1:0]           cpu_mem_addr;
  logic [DATA_W-1:0]           cpu_mem_wdata;
  logic                        cpu_mem_we;
  logic [STRB_W-1:0]           cpu_mem_be;
  logic [DATA_W-1:0]           cpu_mem_rdata;
  logic                        cpu_mem_err;

  logic [NUM_TGT-1:0]          tgt_mem_valid;
  logic [NUM_TGT-1:0]          tgt_mem_ready;
  logic [ADDR_W-1:0]           tgt_mem_addr;
  logic [DATA_W-1:0]           tgt_mem_wdata;
  logic [STRB_W-1:0]           tgt_mem_wstrb;
  logic [NUM_TGT*DATA_W-1:0]   tgt_mem_rdata;

  modport slave (
    input  cpu_mem_valid, cpu_mem_addr, cpu_mem_wdata, cpu_mem_we, cpu_mem_be,
    output cpu_mem_ready, cpu_mem_rdata, cpu_mem_err,
    output tgt_mem_valid, tgt_mem_addr, tgt_mem_wdata, tgt_mem_wstrb,
    input  tgt_mem_ready, tgt_mem_rdata
  );

  modport master (
    output cpu_mem_valid, cpu_mem_addr, cpu_mem_wdata, cpu_mem_we, cpu_mem_be,
    input  cpu_mem_ready, cpu_mem_rdata, cpu_mem_err,
    input  tgt_mem_valid, tgt_mem_addr, tgt_mem_wdata, tgt_mem_wstrb,
    output tgt_mem_ready, tgt_mem_rdata
  );
endinterface

// File: rtl/mcu_subsys_bus_decoder.sv
// CPU-to-target bus decoder: base/mask decode with lowest-index priority,
// select latched for the transaction, error completion for unmapped
// addresses and silent targets, sticky error status for the IRQ line.

// Per-target address match.
module mcu_subsys_bus_decoder_hit #(
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] MASK   = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);
  assign hit = (addr & MASK) == BASE;
endmodule

module mcu_subsys_bus_decoder #(
  parameter int                        NUM_TGT     = 3,
  parameter int                        ADDR_W      = 32,
  parameter int                        DATA_W      = 32,
  parameter logic [NUM_TGT*ADDR_W-1:0] TGT_BASE    = {32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_TGT*ADDR_W-1:0] TGT_MASK    = {3{32'hC000_0000}},
  parameter int                        TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0]         ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  mcu_subsys_bus_decoder_if.slave bus,
  input  logic                 err_clr,
  output logic                 err_irq,
  output logic [ADDR_W-1:0]    err_addr,
  output logic [1:0]           err_cause
);
  // Width 1 minimum so a disabled timeout still yields a legal counter.
  localparam int CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

  state_t             state_q, state_d;
  logic [NUM_TGT-1:0] hit, pick, sel_q, sel_d, mux_sel, tvld_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rd_mux, rdata_c;
  logic               ready_c, err_c, err_set;
  logic [1:0]         cause_d;

  for (genvar g = 0; g < NUM_TGT; g++) begin : g_hit
    mcu_subsys_bus_decoder_hit #(
      .ADDR_W (ADDR_W),
      .BASE   (TGT_BASE[g*ADDR_W +: ADDR_W]),
      .MASK   (TGT_MASK[g*ADDR_W +: ADDR_W])
    ) u_hit (
      .addr (bus.cpu_mem_addr),
      .hit  (hit[g])
    );
  end

  // Isolate the lowest set hit bit: lowest index wins on overlap.
  assign pick    = hit & (~hit + NUM_TGT'(1));
  // Live decode only while IDLE; afterwards the latched select owns the mux.
  assign mux_sel = (state_q == ACTIVE) ? sel_q : pick;

  // Read-data mux over the one-hot select.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_TGT; i++)
      if (mux_sel[i]) rd_mux = rd_mux | bus.tgt_mem_rdata[i*DATA_W +: DATA_W];
  end

  // State, select and timeout counter registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tvld_c  = '0;
    ready_c = 1'b0;
    err_c   = 1'b0;
    rdata_c = '0;
    err_set = 1'b0;
    cause_d = 2'b00;
    case (state_q)
      IDLE: begin
        if (bus.cpu_mem_valid) begin
          if (|hit) begin
            tvld_c = pick;
            sel_d  = pick;
            if (|(pick & bus.tgt_mem_ready)) begin
              ready_c = 1'b1;
              rdata_c = rd_mux;
            end else begin
              state_d = ACTIVE;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            state_d = ERR;
            sel_d   = '0;
            err_set = 1'b1;
            cause_d = 2'b01;
          end
        end
      end
      ACTIVE: begin
        if (!bus.cpu_mem_valid) begin
          // Request withdrawn: abandon quietly.
          state_d = IDLE;
        end else begin
          tvld_c = sel_q;
          if (|(sel_q & bus.tgt_mem_ready)) begin
            ready_c = 1'b1;
            rdata_c = rd_mux;
            state_d = IDLE;
          end else if (TIMEOUT_CYC != 0 && cnt_q == TO_VAL) begin
            state_d = ERR;
            err_set = 1'b1;
            cause_d = 2'b10;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ERR: begin
        if (bus.cpu_mem_valid) begin
          ready_c = 1'b1;
          err_c   = 1'b1;
          rdata_c = ERR_RDATA;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error status; a new error beats a simultaneous clear.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_irq   <= 1'b0;
      err_addr  <= '0;
      err_cause <= 2'b00;
    end else if (err_set) begin
      err_irq   <= 1'b1;
      err_addr  <= bus.cpu_mem_addr;
      err_cause <= cause_d;
    end else if (err_clr) begin
      err_irq   <= 1'b0;
    end
  end

  // Outputs are forced quiet while reset is held, even if the CPU keeps valid up.
  assign bus.tgt_mem_valid = rst_n ? tvld_c : '0;
  assign bus.cpu_mem_ready = rst_n & ready_c;
  assign bus.cpu_mem_err   = rst_n & err_c;
  assign bus.cpu_mem_rdata = rst_n ? rdata_c : '0;
  assign bus.tgt_mem_addr  = bus.cpu_mem_addr;
  assign bus.tgt_mem_wdata = bus.cpu_mem_wdata;
  assign bus.tgt_mem_wstrb = bus.cpu_mem_we ? bus.cpu_mem_be : '0;
endmodule
